op8_sweep_ctrl: RTL



---
 rtl/op8_sweep_ctrl_pkg.sv | 36 +++
 rtl/op8_sweep_ctrl_if.sv | 36 +++
 rtl/op8_sweep_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/op8_sweep_ctrl_pkg.sv
// rtl/op8_sweep_ctrl_pkg.sv - shared types, opcode map and golden model for the op8 sweep sequencer
package op8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_XOR  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_NOTA = 3'd5;
  localparam logic [2:0] OP_NOTB = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

  localparam logic [2:0] OP_LAST = OP_XNOR;

  function automatic logic op8_golden(input logic a, input logic b, input logic [2:0] op);
    logic r;
    case (op)
      OP_XOR:  r = a ^ b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_NOTA: r = ~a;
      OP_NOTB: r = ~b;
      default: r = ~(a ^ b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/op8_sweep_ctrl_if.sv
// rtl/op8_sweep_ctrl_if.sv - request, logic-unit and result handshake bundle for op8_sweep_ctrl
interface op8_sweep_ctrl_if;

  logic       start;
  logic       a_in;
  logic       b_in;
  logic [2:0] S;
  logic       A;
  logic       B;
  logic       op_out;
  logic       busy;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] result;
`ifdef OP8_SWEEP_SELFCHECK_EN
  logic       chk_err;
`endif

  // master: requester, downstream consumer and the logic unit; slave: the sequencer
  modport master (
    output start, a_in, b_in, op_out, res_ready,
    input  S, A, B, busy, res_valid, result
`ifdef OP8_SWEEP_SELFCHECK_EN
    , input chk_err
`endif
  );

  modport slave (
    input  start, a_in, b_in, op_out, res_ready,
    output S, A, B, busy, res_valid, result
`ifdef OP8_SWEEP_SELFCHECK_EN
    , output chk_err
`endif
  );

endinterface

// File: rtl/op8_sweep_ctrl.sv
// rtl/op8_sweep_ctrl.sv - sweeps S over all 8 opcodes of the logic unit and returns the 8 samples; OP8_SWEEP_SELFCHECK_EN adds sticky chk_err
module op8_sweep_ctrl
  import op8_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic             CLK,
  input logic             RST,
  op8_sweep_ctrl_if.slave bus
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [2:0] s_q, s_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic [3:0] cnt_q, cnt_d;
  logic       res_valid_q, res_valid_d;
  logic [7:0] result_q, result_d;
`ifdef OP8_SWEEP_SELFCHECK_EN
  logic       chk_err_q, chk_err_d;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      s_q         <= 3'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      cnt_q       <= 4'd0;
      res_valid_q <= 1'b0;
      result_q    <= 8'h00;
`ifdef OP8_SWEEP_SELFCHECK_EN
      chk_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
`ifdef OP8_SWEEP_SELFCHECK_EN
      chk_err_q   <= chk_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    result_d    = result_q;
`ifdef OP8_SWEEP_SELFCHECK_EN
    chk_err_d   = chk_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.a_in;
          b_d      = bus.b_in;
          s_d      = 3'd0;
          cnt_d    = SETTLE_INIT;
          result_d = 8'h00;
`ifdef OP8_SWEEP_SELFCHECK_EN
          chk_err_d = 1'b0;
`endif
          state_d  = DRIVE;
        end
      end

      DRIVE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d[s_q] = bus.op_out;
`ifdef OP8_SWEEP_SELFCHECK_EN
          if (bus.op_out != op8_golden(a_q, b_q, s_q)) begin
            chk_err_d = 1'b1;
          end
`endif
          // S parks on the last opcode while the result waits in DONE
          if (s_q != OP_LAST) begin
            s_d   = s_q + 3'd1;
            cnt_d = SETTLE_INIT;
          end else begin
            res_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end

      DONE: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          s_d         = 3'd0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.S         = s_q;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.result    = result_q;
`ifdef OP8_SWEEP_SELFCHECK_EN
  assign bus.chk_err   = chk_err_q;
`endif

endmodule
